// File: rtl/cpu_run_checker_if.sv
// rtl/cpu_run_checker_if.sv - check-table and read-port bus between the checker and the core's memories
interface cpu_run_checker_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 4
);
  logic [IDX_W-1:0]  chk_idx;
  logic              chk_kind;
  logic [ADDR_W-1:0] chk_addr;
  logic [DATA_W-1:0] chk_exp;
  logic [4:0]        rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic [ADDR_W-3:0] dm_raddr;
  logic [DATA_W-1:0] dm_rdata;

  // Checker side: requests table entries and drives the read addresses
  modport master (
    output chk_idx, rf_raddr, dm_raddr,
    input  chk_kind, chk_addr, chk_exp, rf_rdata, dm_rdata
  );

  // Table / memory side: answers the requests combinationally
  modport slave (
    input  chk_idx, rf_raddr, dm_raddr,
    output chk_kind, chk_addr, chk_exp, rf_rdata, dm_rdata
  );
endinterface

// File: rtl/cpu_run_checker.sv
// rtl/cpu_run_checker.sv - run controller (budget / self-loop stop) and result checker
module cpu_run_checker #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 30,
  parameter int LOOP_LIMIT = 3,
  parameter int NUM_CHECKS = 8,
  parameter int IDX_W      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   pc,
  input  logic [DATA_W-1:0]   instr,
  cpu_run_checker_if.master   bus,
  output logic                running,
  output logic                done,
  output logic                pass,
  output logic [IDX_W-1:0]    fail_count,
  output logic [IDX_W-1:0]    first_fail_idx,
  output logic [CNT_W-1:0]    cycles,
  output logic [1:0]          halt_cause
);

  localparam int LAST_INT = (NUM_CHECKS > 0) ? NUM_CHECKS - 1 : 0;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(LAST_INT);
  localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] LOOP_CNT   = CNT_W'(LOOP_LIMIT);

  typedef enum logic [1:0] {S_RUN, S_ISSUE, S_COMPARE, S_DONE} state_t;

  state_t             state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic               first_q;
  logic [CNT_W-1:0]   cycles_q;
  logic [CNT_W-1:0]   same_cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   fail_q;
  logic [IDX_W-1:0]   first_fail_q;
  logic [1:0]         cause_q;
  logic               running_q;
  logic               done_q;
  logic               pass_q;
  logic               kind_q;
  logic [DATA_W-1:0]  exp_q;
  logic [4:0]         rf_raddr_q;
  logic [ADDR_W-3:0]  dm_raddr_q;

  logic               pc_match;
  logic               stop_budget;
  logic               stop_loop;
  logic [CNT_W-1:0]   cycles_d;
  logic [CNT_W-1:0]   same_cnt_d;
  logic [IDX_W-1:0]   fail_d;
  logic [DATA_W-1:0]  rd_data;
  logic               mismatch;

  // The instruction is only carried for tracing; it never affects control
  logic unused_instr;
  assign unused_instr = ^instr;

  // Stop detection, saturating counters and the compare of the selected read port
  always_comb begin
    pc_match    = !first_q && (pc == pc_q);
    stop_budget = (cycles_q + CNT_W'(1)) == MAX_CNT;
    stop_loop   = pc_match && ((same_cnt_q + CNT_W'(1)) == LOOP_CNT);
    cycles_d    = (cycles_q == '1) ? cycles_q : cycles_q + CNT_W'(1);
    same_cnt_d  = '0;
    if (pc_match)
      same_cnt_d = (same_cnt_q == '1) ? same_cnt_q : same_cnt_q + CNT_W'(1);
    fail_d      = (fail_q == '1) ? fail_q : fail_q + IDX_W'(1);
    rd_data     = kind_q ? bus.dm_rdata : bus.rf_rdata;
    mismatch    = (rd_data != exp_q);
  end

  // Main FSM: observe the run, then issue/compare each table entry, then hold the verdict
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_RUN;
      pc_q         <= '0;
      first_q      <= 1'b1;
      cycles_q     <= '0;
      same_cnt_q   <= '0;
      idx_q        <= '0;
      fail_q       <= '0;
      first_fail_q <= '0;
      cause_q      <= '0;
      running_q    <= 1'b1;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      kind_q       <= 1'b0;
      exp_q        <= '0;
      rf_raddr_q   <= '0;
      dm_raddr_q   <= '0;
    end else begin
      case (state_q)
        S_RUN: begin
          cycles_q   <= cycles_d;
          pc_q       <= pc;
          first_q    <= 1'b0;
          same_cnt_q <= same_cnt_d;
          if (stop_budget || stop_loop) begin
            cause_q   <= {stop_loop, stop_budget};
            running_q <= 1'b0;
            idx_q     <= '0;
            if (NUM_CHECKS == 0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              pass_q  <= (fail_q == '0);
            end else begin
              state_q <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          kind_q     <= bus.chk_kind;
          exp_q      <= bus.chk_exp;
          rf_raddr_q <= bus.chk_addr[4:0];
          dm_raddr_q <= bus.chk_addr[ADDR_W-1:2];
          state_q    <= S_COMPARE;
        end
        S_COMPARE: begin
          if (mismatch) begin
            fail_q <= fail_d;
            if (fail_q == '0)
              first_fail_q <= idx_q;
          end
          if (idx_q == LAST_IDX) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            pass_q  <= (fail_q == '0) && !mismatch;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            state_q <= S_ISSUE;
          end
        end
        default: begin
          state_q <= S_DONE;
        end
      endcase
    end
  end

  assign bus.chk_idx     = idx_q;
  assign bus.rf_raddr    = rf_raddr_q;
  assign bus.dm_raddr    = dm_raddr_q;
  assign running         = running_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign fail_count      = fail_q;
  assign first_fail_idx  = first_fail_q;
  assign cycles          = cycles_q;
  assign halt_cause      = cause_q;

endmodule

// File: tb/tb_cpu_run_checker.sv
// tb/tb_cpu_run_checker.sv - directed self-checking bench for cpu_run_checker
module tb_cpu_run_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc  = 32'h0;
  logic [31:0] instr = 32'h0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_run_checker_if bus_a ();
  cpu_run_checker_if bus_b ();
  cpu_run_checker_if bus_c ();

  logic        a_running, a_done, a_pass;
  logic [3:0]  a_fail, a_ffi;
  logic [15:0] a_cycles;
  logic [1:0]  a_cause;
  logic        b_running, b_done, b_pass;
  logic [3:0]  b_fail, b_ffi;
  logic [15:0] b_cycles;
  logic [1:0]  b_cause;
  logic        c_running, c_done, c_pass;
  logic [3:0]  c_fail, c_ffi;
  logic [15:0] c_cycles;
  logic [1:0]  c_cause;

  // Memory contents seen by the three-entry table
  logic [31:0] rf8   = 32'h5;
  logic [31:0] m50   = 32'hB;
  logic [31:0] m54   = 32'h7;
  logic [31:0] addr2 = 32'h54;

  assign bus_a.chk_kind = 1'b0;
  assign bus_a.chk_addr = '0;
  assign bus_a.chk_exp  = '0;
  assign bus_a.rf_rdata = '0;
  assign bus_a.dm_rdata = '0;
  assign bus_b.chk_kind = 1'b0;
  assign bus_b.chk_addr = '0;
  assign bus_b.chk_exp  = '0;
  assign bus_b.rf_rdata = '0;
  assign bus_b.dm_rdata = '0;

  always_comb begin
    bus_c.chk_kind = 1'b0;
    bus_c.chk_addr = '0;
    bus_c.chk_exp  = '0;
    case (bus_c.chk_idx)
      4'd0: begin bus_c.chk_kind = 1'b0; bus_c.chk_addr = 32'h8;  bus_c.chk_exp = 32'h5; end
      4'd1: begin bus_c.chk_kind = 1'b1; bus_c.chk_addr = 32'h50; bus_c.chk_exp = 32'hB; end
      4'd2: begin bus_c.chk_kind = 1'b1; bus_c.chk_addr = addr2;  bus_c.chk_exp = 32'h7; end
      default: ;
    endcase
  end

  assign bus_c.rf_rdata = (bus_c.rf_raddr == 5'd8) ? rf8 : 32'hDEAD0000;
  assign bus_c.dm_rdata = (bus_c.dm_raddr == 30'h14) ? m50 :
                          (bus_c.dm_raddr == 30'h15) ? m54 : 32'hDEAD0001;

  cpu_run_checker #(.MAX_CYCLES(30), .LOOP_LIMIT(3), .NUM_CHECKS(0)) u_a (
    .clk(clk), .rst(rst), .pc(pc), .instr(instr), .bus(bus_a),
    .running(a_running), .done(a_done), .pass(a_pass), .fail_count(a_fail),
    .first_fail_idx(a_ffi), .cycles(a_cycles), .halt_cause(a_cause)
  );

  cpu_run_checker #(.MAX_CYCLES(5), .LOOP_LIMIT(4), .NUM_CHECKS(0)) u_b (
    .clk(clk), .rst(rst), .pc(pc), .instr(instr), .bus(bus_b),
    .running(b_running), .done(b_done), .pass(b_pass), .fail_count(b_fail),
    .first_fail_idx(b_ffi), .cycles(b_cycles), .halt_cause(b_cause)
  );

  cpu_run_checker #(.MAX_CYCLES(30), .LOOP_LIMIT(3), .NUM_CHECKS(3)) u_c (
    .clk(clk), .rst(rst), .pc(pc), .instr(instr), .bus(bus_c),
    .running(c_running), .done(c_done), .pass(c_pass), .fail_count(c_fail),
    .first_fail_idx(c_ffi), .cycles(c_cycles), .halt_cause(c_cause)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset with PC held at 0x3000, then run u_c into a self-loop stop after 4 edges
  task automatic run_c_to_stop;
    rst = 1'b1;
    pc  = 32'h3000;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("c_running_before_stop", 32'(c_running), 32'd1);
    tick();
    chk("c_running_at_stop", 32'(c_running), 32'd0);
    chk("c_cause_loop", 32'(c_cause), 32'd2);
    chk("c_cycles_at_stop", 32'(c_cycles), 32'd4);
    chk("c_chk_idx_issue0", 32'(bus_c.chk_idx), 32'd0);
  endtask

  initial begin
    // Reset values
    rst = 1'b1;
    pc  = 32'h0;
    tick();
    chk("rst_running", 32'(a_running), 32'd1);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_pass", 32'(a_pass), 32'd0);
    chk("rst_fail", 32'(a_fail), 32'd0);
    chk("rst_ffi", 32'(a_ffi), 32'd0);
    chk("rst_cycles", 32'(a_cycles), 32'd0);
    chk("rst_cause", 32'(a_cause), 32'd0);
    chk("rst_chk_idx", 32'(bus_c.chk_idx), 32'd0);
    chk("rst_rf_raddr", 32'(bus_c.rf_raddr), 32'd0);
    chk("rst_dm_raddr", 32'(bus_c.dm_raddr), 32'd0);

    // Budget stop: PC advances every cycle
    rst = 1'b0;
    for (int k = 1; k <= 29; k++) begin
      pc = 32'(4 * k);
      tick();
    end
    chk("budget_running_29", 32'(a_running), 32'd1);
    chk("budget_cycles_29", 32'(a_cycles), 32'd29);
    pc = 32'd120;
    tick();
    chk("budget_running_30", 32'(a_running), 32'd0);
    chk("budget_cycles_30", 32'(a_cycles), 32'd30);
    chk("budget_cause", 32'(a_cause), 32'd1);
    chk("budget_done", 32'(a_done), 32'd1);
    chk("budget_pass", 32'(a_pass), 32'd1);
    pc = 32'd500;
    tick();
    chk("budget_cycles_hold", 32'(a_cycles), 32'd30);

    // Self-loop: PC 0x3000 during reset, 0x3004, then held at 0x3008
    rst = 1'b1;
    pc  = 32'h3000;
    tick();
    chk("loop_rst_cycles", 32'(a_cycles), 32'd0);
    chk("loop_rst_done", 32'(a_done), 32'd0);
    rst = 1'b0;
    pc  = 32'h3004;
    tick();
    pc  = 32'h3008;
    repeat (3) tick();
    chk("loop_running_4", 32'(a_running), 32'd1);
    chk("loop_cycles_4", 32'(a_cycles), 32'd4);
    tick();
    chk("loop_running_5", 32'(a_running), 32'd0);
    chk("loop_cause", 32'(a_cause), 32'd2);
    chk("loop_cycles_5", 32'(a_cycles), 32'd5);

    // Simultaneous budget and loop stop on u_b
    rst = 1'b1;
    pc  = 32'h3000;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("sim_running_4", 32'(b_running), 32'd1);
    tick();
    chk("sim_running_5", 32'(b_running), 32'd0);
    chk("sim_cause", 32'(b_cause), 32'd3);
    chk("sim_cycles", 32'(b_cycles), 32'd5);
    chk("sim_done", 32'(b_done), 32'd1);

    // All checks pass
    rf8 = 32'h5; m50 = 32'hB; m54 = 32'h7; addr2 = 32'h54;
    run_c_to_stop();
    tick();
    chk("pass_rf_raddr", 32'(bus_c.rf_raddr), 32'd8);
    tick();
    chk("pass_fail_after0", 32'(c_fail), 32'd0);
    tick();
    chk("pass_dm_raddr1", 32'(bus_c.dm_raddr), 32'h14);
    chk("pass_chk_idx1", 32'(bus_c.chk_idx), 32'd1);
    tick();
    tick();
    chk("pass_dm_raddr2", 32'(bus_c.dm_raddr), 32'h15);
    chk("pass_done_early", 32'(c_done), 32'd0);
    tick();
    chk("pass_done", 32'(c_done), 32'd1);
    chk("pass_pass", 32'(c_pass), 32'd1);
    chk("pass_fail", 32'(c_fail), 32'd0);
    chk("pass_ffi", 32'(c_ffi), 32'd0);
    pc = 32'h4000;
    repeat (3) tick();
    chk("pass_done_hold", 32'(c_done), 32'd1);
    chk("pass_cycles_hold", 32'(c_cycles), 32'd4);

    // Mismatches on entries 0 and 2; entry 2 address carries byte-offset bits
    rf8 = 32'h0; m54 = 32'h8; addr2 = 32'h57;
    run_c_to_stop();
    repeat (2) tick();
    chk("mis_fail_after0", 32'(c_fail), 32'd1);
    repeat (3) tick();
    chk("mis_dm_raddr_offset", 32'(bus_c.dm_raddr), 32'h15);
    tick();
    chk("mis_done", 32'(c_done), 32'd1);
    chk("mis_fail", 32'(c_fail), 32'd2);
    chk("mis_ffi", 32'(c_ffi), 32'd0);
    chk("mis_pass", 32'(c_pass), 32'd0);

    // Reset during COMPARE(1)
    rf8 = 32'h5; m54 = 32'h7; addr2 = 32'h54;
    run_c_to_stop();
    repeat (3) tick();
    rst = 1'b1;
    #2;
    chk("mid_rst_running", 32'(c_running), 32'd1);
    chk("mid_rst_cycles", 32'(c_cycles), 32'd0);
    chk("mid_rst_chk_idx", 32'(bus_c.chk_idx), 32'd0);
    chk("mid_rst_dm_raddr", 32'(bus_c.dm_raddr), 32'd0);
    chk("mid_rst_rf_raddr", 32'(bus_c.rf_raddr), 32'd0);
    chk("mid_rst_cause", 32'(c_cause), 32'd0);
    chk("mid_rst_done", 32'(c_done), 32'd0);
    rst = 1'b0;
    pc  = 32'h5000;
    tick();
    chk("mid_rst_restart_cycles", 32'(c_cycles), 32'd1);
    chk("mid_rst_restart_running", 32'(c_running), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
